sdes_iter_core: RTL and testbench
=================================

SDES_ITER_CORE -- requirements
Module: sdes_iter_core

Interface
REQ-001 Parameter LANES, default 1, number of independent 8-bit S-DES blocks processed in parallel (1..8).
REQ-002 Parameter CNT_W, default 16, width of the completed-block counter (2..32).
REQ-003 i_clk  input  1  sole clock, all state on rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_valid  input  1  input block and key valid.
REQ-006 o_ready  output  1  core can accept a block.
REQ-007 i_data  input  8*LANES  plaintext (encrypt) or ciphertext (decrypt); lane k = bits [8k+7:8k].
REQ-008 i_key  input  10  S-DES master key, bit 9 = key bit 1.
REQ-009 i_decrypt  input  1  0 = encrypt, 1 = decrypt.
REQ-010 o_valid  output  1  result valid.
REQ-011 i_ready  input  1  downstream accepts result.
REQ-012 o_data  output  8*LANES  result, same lane mapping as i_data.
REQ-013 o_blk_count  output  CNT_W  number of completed output handshakes.

Function
REQ-014 The key schedule SHALL be computed internally from the latched key: P10 = (3 5 2 7 4 10 1 9 8 6); LS-1 on each 5-bit half, then P8 = (6 3 7 4 8 5 10 9) gives K1; a further LS-2 on each half, then P8 gives K2 (position 1 = MSB).
REQ-015 Each lane SHALL use the existing permutation_ip, permutation_ep, switch_s0, switch_s1, permutation_p4 and permutation_inverse_ip blocks for the round function, identical in bit mapping to the combinational encryption datapath.
REQ-016 FSM states SHALL be IDLE, R1, R2, DONE; o_ready = 1 only in IDLE.
REQ-017 Accept occurs on a rising edge with state IDLE and i_valid = 1: latch IP(i_data) per lane, i_key and i_decrypt; go to R1.
REQ-018 R1 SHALL apply one Feistel round to every lane with K1 (encrypt) or K2 (decrypt), then swap the 4-bit halves; go to R2.
REQ-019 R2 SHALL apply one Feistel round with K2 (encrypt) or K1 (decrypt), without a swap, load o_data = IP^-1 of the result, and go to DONE.
REQ-020 Latency: o_valid SHALL rise exactly 3 clock edges after the accept edge (accept, R1, R2).
REQ-021 In DONE, o_valid = 1 and o_data SHALL hold stable until a rising edge with i_ready = 1, then go to IDLE with o_valid = 0.
REQ-022 No accept SHALL occur in the same edge as an output handshake; minimum spacing is one block per 4 clocks.
REQ-023 Changes on i_data, i_key, i_decrypt or i_valid outside IDLE SHALL be ignored.
REQ-024 i_valid = 1 in non-IDLE states SHALL NOT be buffered or dropped silently; the upstream holds it until o_ready = 1.
REQ-025 o_blk_count SHALL increment by 1 on each output handshake and wrap modulo 2^CNT_W with no flag.
REQ-026 Lanes SHALL be fully independent except for sharing key, mode and handshake; there is no inter-lane chaining (ECB).
REQ-027 o_data SHALL retain the last result after returning to IDLE until the next R2 load.

Reset
REQ-028 Asserting i_rst_n low SHALL immediately force state IDLE, o_valid = 0, o_data = 0, o_blk_count = 0 and clear all internal registers, regardless of the current state.
REQ-029 o_ready SHALL be 1 during reset and SHALL remain 1 on the first edge after release, so that the first edge after release can accept a block.
REQ-030 A block in flight at reset SHALL be discarded, with no o_valid and no count increment.

Verification
REQ-031 LANES=1, key 1010000010, encrypt, data 10010111 -> o_valid on the 3rd edge after accept, o_data 00111000 (K1 10100100, K2 01000011).
REQ-032 Same key, decrypt, data 00111000 -> o_data 10010111; sweep all 256 blocks x 16 random keys, decrypt(encrypt(x)) = x.
REQ-033 LANES=2, key 1010000010, encrypt, data {10010111, 00000000} -> upper lane 00111000; lower lane matches single-lane model.
REQ-034 i_ready held 0 for 5 cycles in DONE while i_data/i_key toggle -> o_data, o_valid stable, o_ready 0, count unchanged; count becomes 1 after handshake.
REQ-035 i_rst_n pulsed low during R2 -> o_valid never asserts, o_blk_count 0, o_ready 1; next block completes normally.
REQ-036 CNT_W=2, 5 back-to-back blocks with i_ready=1 -> o_blk_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/sdes_iter_core.sv
// Iterative S-DES core: one Feistel round per clock, LANES independent 8-bit blocks sharing
// a single key, mode and valid/ready handshake (ECB).

module permutation_ip (
  input  logic [7:0] i_data,
  output logic [7:0] o_data
);
  // IP = (2 6 3 1 4 8 5 7), position 1 = MSB
  assign o_data = {i_data[6], i_data[2], i_data[5], i_data[7],
                   i_data[4], i_data[0], i_data[3], i_data[1]};
endmodule

module permutation_inverse_ip (
  input  logic [7:0] i_data,
  output logic [7:0] o_data
);
  // IP^-1 = (4 1 3 5 7 2 8 6)
  assign o_data = {i_data[4], i_data[7], i_data[5], i_data[3],
                   i_data[1], i_data[6], i_data[0], i_data[2]};
endmodule

module permutation_ep (
  input  logic [3:0] i_data,
  output logic [7:0] o_data
);
  // E/P = (4 1 2 3 2 3 4 1)
  assign o_data = {i_data[0], i_data[3], i_data[2], i_data[1],
                   i_data[2], i_data[1], i_data[0], i_data[3]};
endmodule

module permutation_p4 (
  input  logic [3:0] i_data,
  output logic [3:0] o_data
);
  // P4 = (2 4 3 1)
  assign o_data = {i_data[2], i_data[0], i_data[1], i_data[3]};
endmodule

module switch_s0 (
  input  logic [3:0] i_data,
  output logic [1:0] o_data
);
  logic [3:0] w_idx;

  // Row from outer bits (1,4), column from inner bits (2,3)
  assign w_idx = {i_data[3], i_data[0], i_data[2], i_data[1]};

  always_comb begin
    o_data = 2'd0;
    case (w_idx)
      4'd0:  o_data = 2'd1;
      4'd1:  o_data = 2'd0;
      4'd2:  o_data = 2'd3;
      4'd3:  o_data = 2'd2;
      4'd4:  o_data = 2'd3;
      4'd5:  o_data = 2'd2;
      4'd6:  o_data = 2'd1;
      4'd7:  o_data = 2'd0;
      4'd8:  o_data = 2'd0;
      4'd9:  o_data = 2'd2;
      4'd10: o_data = 2'd1;
      4'd11: o_data = 2'd3;
      4'd12: o_data = 2'd3;
      4'd13: o_data = 2'd1;
      4'd14: o_data = 2'd3;
      4'd15: o_data = 2'd2;
      default: o_data = 2'd0;
    endcase
  end
endmodule

module switch_s1 (
  input  logic [3:0] i_data,
  output logic [1:0] o_data
);
  logic [3:0] w_idx;

  assign w_idx = {i_data[3], i_data[0], i_data[2], i_data[1]};

  always_comb begin
    o_data = 2'd0;
    case (w_idx)
      4'd0:  o_data = 2'd0;
      4'd1:  o_data = 2'd1;
      4'd2:  o_data = 2'd2;
      4'd3:  o_data = 2'd3;
      4'd4:  o_data = 2'd2;
      4'd5:  o_data = 2'd0;
      4'd6:  o_data = 2'd1;
      4'd7:  o_data = 2'd3;
      4'd8:  o_data = 2'd3;
      4'd9:  o_data = 2'd0;
      4'd10: o_data = 2'd1;
      4'd11: o_data = 2'd0;
      4'd12: o_data = 2'd2;
      4'd13: o_data = 2'd1;
      4'd14: o_data = 2'd0;
      4'd15: o_data = 2'd3;
      default: o_data = 2'd0;
    endcase
  end
endmodule

module sdes_iter_core #(
  parameter int unsigned LANES = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [8*LANES-1:0]   i_data,
  input  logic [9:0]           i_key,
  input  logic                 i_decrypt,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [8*LANES-1:0]   o_data,
  output logic [CNT_W-1:0]     o_blk_count
);

  typedef enum logic [1:0] {IDLE, R1, R2, DONE} state_t;

  state_t               r_state;
  logic                 r_ready;
  logic                 r_valid;
  logic [9:0]           r_key;
  logic                 r_dec;
  logic [8*LANES-1:0]   r_blk;
  logic [8*LANES-1:0]   r_out;
  logic [CNT_W-1:0]     r_cnt;

  logic [9:0]           w_p10;
  logic [9:0]           w_ls1;
  logic [9:0]           w_ls3;
  logic [7:0]           w_k1;
  logic [7:0]           w_k2;
  logic                 w_use_k1;
  logic [7:0]           w_rk;
  logic [8*LANES-1:0]   w_ip;
  logic [8*LANES-1:0]   w_swp;
  logic [8*LANES-1:0]   w_res;

  // Key schedule from the latched key: P10, LS-1 -> P8 = K1, further LS-2 -> P8 = K2
  assign w_p10 = {r_key[7], r_key[5], r_key[8], r_key[3], r_key[6],
                  r_key[0], r_key[9], r_key[1], r_key[2], r_key[4]};
  assign w_ls1 = {w_p10[8:5], w_p10[9], w_p10[3:0], w_p10[4]};
  assign w_ls3 = {w_ls1[7:5], w_ls1[9:8], w_ls1[2:0], w_ls1[4:3]};
  assign w_k1  = {w_ls1[4], w_ls1[7], w_ls1[3], w_ls1[6],
                  w_ls1[2], w_ls1[5], w_ls1[0], w_ls1[1]};
  assign w_k2  = {w_ls3[4], w_ls3[7], w_ls3[3], w_ls3[6],
                  w_ls3[2], w_ls3[5], w_ls3[0], w_ls3[1]};

  // Decrypt runs the subkeys in reverse order
  assign w_use_k1 = (r_state == R1) ^ r_dec;
  assign w_rk     = w_use_k1 ? w_k1 : w_k2;

  for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
    logic [3:0] w_l;
    logic [3:0] w_r;
    logic [7:0] w_ep;
    logic [7:0] w_x;
    logic [1:0] w_s0;
    logic [1:0] w_s1;
    logic [3:0] w_p4;
    logic [3:0] w_fl;

    permutation_ip u_ip (
      .i_data (i_data[8*g +: 8]),
      .o_data (w_ip[8*g +: 8])
    );

    assign w_l = r_blk[8*g+4 +: 4];
    assign w_r = r_blk[8*g +: 4];

    permutation_ep u_ep (
      .i_data (w_r),
      .o_data (w_ep)
    );

    assign w_x = w_ep ^ w_rk;

    switch_s0 u_s0 (
      .i_data (w_x[7:4]),
      .o_data (w_s0)
    );

    switch_s1 u_s1 (
      .i_data (w_x[3:0]),
      .o_data (w_s1)
    );

    permutation_p4 u_p4 (
      .i_data ({w_s0, w_s1}),
      .o_data (w_p4)
    );

    assign w_fl = w_l ^ w_p4;
    assign w_swp[8*g +: 8] = {w_r, w_fl};

    permutation_inverse_ip u_ipi (
      .i_data ({w_fl, w_r}),
      .o_data (w_res[8*g +: 8])
    );
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_key   <= '0;
      r_dec   <= 1'b0;
      r_blk   <= '0;
      r_out   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_valid) begin
            r_blk   <= w_ip;
            r_key   <= i_key;
            r_dec   <= i_decrypt;
            r_ready <= 1'b0;
            r_state <= R1;
          end
        end
        R1: begin
          r_blk   <= w_swp;
          r_state <= R2;
        end
        R2: begin
          r_out   <= w_res;
          r_valid <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          if (i_ready) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_cnt   <= r_cnt + CNT_W'(1);
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready     = r_ready;
  assign o_valid     = r_valid;
  assign o_data      = r_out;
  assign o_blk_count = r_cnt;

endmodule

// File: tb/tb_sdes_iter_core.sv
// Self-checking bench for sdes_iter_core: known vectors, table, corner sequences and a
// random encrypt/decrypt sweep against a table-driven S-DES reference model.

module tb_sdes_iter_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT A: single lane, 16-bit counter
  logic        a_valid, a_ready, a_dec, a_ovalid, a_iready;
  logic [7:0]  a_data, a_odata;
  logic [9:0]  a_key;
  logic [15:0] a_cnt;

  // DUT B: two lanes, 2-bit counter
  logic        b_valid, b_ready, b_dec, b_ovalid, b_iready;
  logic [15:0] b_data, b_odata;
  logic [9:0]  b_key;
  logic [1:0]  b_cnt;

  sdes_iter_core #(.LANES(1), .CNT_W(16)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(a_valid), .o_ready(a_ready),
    .i_data(a_data), .i_key(a_key), .i_decrypt(a_dec), .o_valid(a_ovalid),
    .i_ready(a_iready), .o_data(a_odata), .o_blk_count(a_cnt)
  );

  sdes_iter_core #(.LANES(2), .CNT_W(2)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(b_valid), .o_ready(b_ready),
    .i_data(b_data), .i_key(b_key), .i_decrypt(b_dec), .o_valid(b_ovalid),
    .i_ready(b_iready), .o_data(b_odata), .o_blk_count(b_cnt)
  );

  int checks = 0;
  int errors = 0;
  int a_ops = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef int tab_t[10];
  tab_t t_p10 = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
  tab_t t_p8  = '{6, 3, 7, 4, 8, 5, 10, 9, 0, 0};
  tab_t t_ip  = '{2, 6, 3, 1, 4, 8, 5, 7, 0, 0};
  tab_t t_ipi = '{4, 1, 3, 5, 7, 2, 8, 6, 0, 0};
  tab_t t_ep  = '{4, 1, 2, 3, 2, 3, 4, 1, 0, 0};
  tab_t t_p4  = '{2, 4, 3, 1, 0, 0, 0, 0, 0, 0};
  int sb0[4][4] = '{'{1, 0, 3, 2}, '{3, 2, 1, 0}, '{0, 2, 1, 3}, '{3, 1, 3, 2}};
  int sb1[4][4] = '{'{0, 1, 2, 3}, '{2, 0, 1, 3}, '{3, 0, 1, 0}, '{2, 1, 0, 3}};

  function automatic int perm(input int x, input int nin, input int nout, input tab_t t);
    int res = 0;
    for (int i = 0; i < nout; i++) res = (res << 1) | ((x >> (nin - t[i])) & 1);
    return res;
  endfunction

  function automatic int rotl5(input int v, input int n);
    return ((v << n) | (v >> (5 - n))) & 31;
  endfunction

  function automatic int ffun(input int r, input int k);
    int e, a, b, s0, s1;
    e  = perm(r, 4, 8, t_ep) ^ k;
    a  = e >> 4;
    b  = e & 15;
    s0 = sb0[((a >> 3) & 1) * 2 + (a & 1)][(a >> 1) & 3];
    s1 = sb1[((b >> 3) & 1) * 2 + (b & 1)][(b >> 1) & 3];
    return perm((s0 << 2) | s1, 4, 4, t_p4);
  endfunction

  function automatic int sdes(input int blk, input int key, input bit dec);
    int p, l, r, k1, k2, ka, kb, x, hl, hr, tmp;
    p  = perm(key, 10, 10, t_p10);
    l  = p >> 5;
    r  = p & 31;
    k1 = perm((rotl5(l, 1) << 5) | rotl5(r, 1), 10, 8, t_p8);
    k2 = perm((rotl5(l, 3) << 5) | rotl5(r, 3), 10, 8, t_p8);
    ka = dec ? k2 : k1;
    kb = dec ? k1 : k2;
    x  = perm(blk, 8, 8, t_ip);
    hl = (x >> 4) ^ ffun(x & 15, ka);
    hr = x & 15;
    tmp = hl; hl = hr; hr = tmp;
    hl = hl ^ ffun(hr, kb);
    return perm((hl << 4) | hr, 8, 8, t_ipi);
  endfunction

  // ---------------- drivers (called at a falling edge) ----------------
  task automatic op_a(input logic [7:0] d, input logic [9:0] k, input bit dec,
                      output int res, output int lat);
    int n = 0;
    a_data = d; a_key = k; a_dec = dec; a_valid = 1'b1;
    while (!a_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    a_valid = 1'b0;
    a_data  = 8'($urandom);
    a_key   = 10'($urandom);
    lat = 1;
    while (!a_ovalid && lat < 10) begin @(negedge clk); lat++; end
    res = int'(a_odata);
    a_iready = 1'b1;
    @(negedge clk);
    a_iready = 1'b0;
    a_ops++;
  endtask

  task automatic op_b(input logic [15:0] d, input logic [9:0] k, input bit dec,
                      output int res, output int lat);
    int n = 0;
    b_data = d; b_key = k; b_dec = dec; b_valid = 1'b1;
    while (!b_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    b_valid = 1'b0;
    lat = 1;
    while (!b_ovalid && lat < 10) begin @(negedge clk); lat++; end
    res = int'(b_odata);
    b_iready = 1'b1;
    @(negedge clk);
    b_iready = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] key;
    bit         dec;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[8];
  localparam logic [9:0] KEY0 = 10'b1010000010;

  initial begin
    int res, lat, n;
    logic [7:0] hold;

    a_valid = 0; a_data = 0; a_key = 0; a_dec = 0; a_iready = 0;
    b_valid = 0; b_data = 0; b_key = 0; b_dec = 0; b_iready = 0;

    vecs[0] = '{8'b10010111, KEY0, 1'b0, 8'b00111000};
    vecs[1] = '{8'b00111000, KEY0, 1'b1, 8'b10010111};
    for (int i = 2; i < 8; i++) begin
      vecs[i].data = 8'($urandom);
      vecs[i].key  = 10'($urandom);
      vecs[i].dec  = 1'(i & 1);
      vecs[i].exp  = 8'(sdes(int'(vecs[i].data), int'(vecs[i].key), vecs[i].dec));
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", int'(a_ready), 1);
    chk("rst_ovalid", int'(a_ovalid), 0);
    chk("rst_odata", int'(a_odata), 0);
    chk("rst_cnt", int'(a_cnt), 0);
    chk("rst_b_ready", int'(b_ready), 1);
    rst_n = 1'b1;

    // Known vector, accepted on the first edge after release, then stalled in DONE
    a_data = 8'b10010111; a_key = KEY0; a_dec = 1'b0; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    lat = 1;
    while (!a_ovalid && lat < 10) begin @(negedge clk); lat++; end
    chk("first_latency", lat, 3);
    chk("known_enc", int'(a_odata), 8'h38);
    for (int i = 0; i < 5; i++) begin
      a_data = 8'($urandom); a_key = 10'($urandom); a_dec = 1'($urandom);
      a_valid = 1'($urandom);
      @(negedge clk);
      chk("stall_odata", int'(a_odata), 8'h38);
      chk("stall_ovalid", int'(a_ovalid), 1);
      chk("stall_ready", int'(a_ready), 0);
      chk("stall_cnt", int'(a_cnt), 0);
    end
    a_valid = 1'b0; a_iready = 1'b1;
    @(negedge clk);
    a_iready = 1'b0;
    chk("hs_cnt", int'(a_cnt), 1);
    chk("hs_ovalid", int'(a_ovalid), 0);
    chk("hs_ready", int'(a_ready), 1);
    chk("hold_odata", int'(a_odata), 8'h38);

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      op_a(vecs[i].data, vecs[i].key, vecs[i].dec, res, lat);
      chk($sformatf("vec%0d_data", i), res, int'(vecs[i].exp));
      chk($sformatf("vec%0d_lat", i), lat, 3);
    end

    // Reset while a block sits in R2
    a_data = 8'h5A; a_key = KEY0; a_dec = 1'b0; a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_ovalid", int'(a_ovalid), 0);
    chk("midrst_ready", int'(a_ready), 1);
    chk("midrst_cnt", int'(a_cnt), 0);
    chk("midrst_odata", int'(a_odata), 0);
    n = 0;
    repeat (3) begin @(negedge clk); if (a_ovalid) n++; end
    chk("midrst_no_valid", n, 0);
    rst_n = 1'b1;
    a_ops = 0;
    op_a(8'hC3, KEY0, 1'b0, res, lat);
    chk("postrst_data", res, sdes(8'hC3, int'(KEY0), 1'b0));
    chk("postrst_lat", lat, 3);
    chk("postrst_cnt", int'(a_cnt), 1);

    // Two lanes: independent ECB blocks
    op_b({8'b10010111, 8'b00000000}, KEY0, 1'b0, res, lat);
    chk("lane_hi", (res >> 8) & 255, 8'h38);
    chk("lane_lo", res & 255, sdes(0, int'(KEY0), 1'b0));
    chk("lane_lat", lat, 3);
    for (int i = 0; i < 3; i++) begin
      logic [15:0] d;
      logic [9:0]  k;
      bit          dm;
      d = 16'($urandom); k = 10'($urandom); dm = 1'($urandom);
      op_b(d, k, dm, res, lat);
      chk("lane_rnd_hi", (res >> 8) & 255, sdes(int'(d[15:8]), int'(k), dm));
      chk("lane_rnd_lo", res & 255, sdes(int'(d[7:0]), int'(k), dm));
    end

    // Counter wrap at CNT_W=2: reset, then five back-to-back blocks
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    b_data = 16'hA55A; b_key = KEY0; b_dec = 1'b0; b_valid = 1'b1; b_iready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n = 0;
      while (!b_ovalid && n < 12) begin @(negedge clk); n++; end
      chk("b2b_valid", int'(b_ovalid), 1);
      chk("b2b_data", int'(b_odata),
          (sdes(8'hA5, int'(KEY0), 1'b0) << 8) | sdes(8'h5A, int'(KEY0), 1'b0));
      @(negedge clk);
      if (i == 4) b_valid = 1'b0;
      chk($sformatf("b2b_cnt%0d", i), int'(b_cnt), (i + 1) % 4);
    end
    b_iready = 1'b0;

    // Random keys: encrypt against the model, then decrypt back
    a_ops = 0;
    for (int k = 0; k < 16; k++) begin
      logic [9:0] key;
      key = 10'($urandom_range(0, 1023));
      for (int x = 0; x < 256; x++) begin
        int ct;
        op_a(8'(x), key, 1'b0, ct, lat);
        chk("sweep_enc", ct, sdes(x, int'(key), 1'b0));
        op_a(8'(ct), key, 1'b1, res, lat);
        chk("sweep_dec", res, x);
      end
    end
    chk("sweep_cnt", int'(a_cnt), a_ops & 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
